mod_mul_pipe: RTL and testbench

- Pipelined modular multiplier over q = 3329, feeding the butterfly unit (bu) datapath.
- Forms the raw product c = a*b, then reduces it with Barrett reduction (k = 32, MU = floor(2^32/q)).
- Returns a fully reduced residue in [0, q-1] over a valid/ready stream with tag passthrough.
- This is the producer and consumer end of the 32-bit-product-to-residue reduction interface, made sequential and flow-controlled.

---
 rtl/ntt_pkg.sv | 13 +
 rtl/mod_mul_pipe_if.sv | 28 ++
 rtl/barrett_qest.sv | 12 +
 rtl/mod_mul_pipe.sv | 115 +++++++++++
 tb/tb_mod_mul_pipe.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the q = 3329 modular arithmetic datapath.
// Exports Q, MU (Barrett constant, k = 32), COEF_W, coef_t and prod_t.
package ntt_pkg;

  localparam int COEF_W = 12;

  localparam logic [11:0] Q  = 12'd3329;
  localparam logic [31:0] MU = 32'h0013AFB7;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [31:0]       prod_t;

endpackage

// File: rtl/mod_mul_pipe_if.sv
// Valid/ready stream bundle for mod_mul_pipe: operand pair + tag in,
// residue + tag out. master = producer/consumer side, slave = the multiplier.
interface mod_mul_pipe_if #(
  parameter int TAG_W = 8
);
  import ntt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  coef_t            in_a;
  coef_t            in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  coef_t            out_res;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );

endinterface

// File: rtl/barrett_qest.sv
// Combinational Barrett quotient estimate: qe = (c * MU) >> 32.
// Ports: c (prod_t) in, qe (prod_t) out.
module barrett_qest
  import ntt_pkg::*;
(
  input  prod_t c,
  output prod_t qe
);

  assign qe = 32'(({32'd0, c} * {32'd0, MU}) >> 32);

endmodule

// File: rtl/mod_mul_pipe.sv
// 3-stage pipelined (a*b) mod 3329 with Barrett reduction and tag passthrough.
// Ports: clk, rst_n, bus (mod_mul_pipe_if.slave); range_err if MODMUL_RANGE_CHECK_EN.
module mod_mul_pipe
  import ntt_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MODMUL_RANGE_CHECK_EN
  output logic range_err,
`endif
  mod_mul_pipe_if.slave bus
);

  logic             en;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  prod_t            c1_q, c1_d, c2_q, c2_d;
  prod_t            qe2_q, qe2_d, qe;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  coef_t            res3_q, res3_d;
  logic [12:0]      t;

  barrett_qest u_qest (
    .c  (c1_q),
    .qe (qe)
  );

  // Quotient error is at most 1, so one subtract lands in [0, Q-1].
  always_comb begin
    t = 13'(c2_q - qe2_q * 32'(Q));
  end

  always_comb begin
    en     = !v3_q || bus.out_ready;
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    c1_d   = c1_q;
    c2_d   = c2_q;
    qe2_d  = qe2_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    tag3_d = tag3_q;
    res3_d = res3_q;
    if (en) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (bus.in_valid) begin
        c1_d   = prod_t'(bus.in_a) * prod_t'(bus.in_b);
        tag1_d = bus.in_tag;
      end
      if (v1_q) begin
        c2_d   = c1_q;
        qe2_d  = qe;
        tag2_d = tag1_q;
      end
      if (v2_q) begin
        res3_d = (t >= 13'(Q)) ? 12'(t - 13'(Q)) : t[11:0];
        tag3_d = tag2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      c1_q   <= '0;
      c2_q   <= '0;
      qe2_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      res3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      qe2_q  <= qe2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
      res3_q <= res3_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v3_q;
  assign bus.out_res   = res3_q;
  assign bus.out_tag   = tag3_q;

`ifdef MODMUL_RANGE_CHECK_EN
  logic rerr_q, rerr_d;

  always_comb begin
    rerr_d = rerr_q
           | (bus.in_valid && en
              && (bus.in_a >= Q || bus.in_b >= Q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rerr_q <= 1'b0;
    else        rerr_q <= rerr_d;
  end

  assign range_err = rerr_q;
`endif

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Directed + random self-checking bench for mod_mul_pipe.
// Covers latency, back-to-back, stall, random stream, reset flush, range flag.
module tb_mod_mul_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [19:0] exp_q[$];
  bit   acc;
  int   sent;
  int   cycles;

`ifdef MODMUL_RANGE_CHECK_EN
  logic range_err;
`endif

  always #5 clk = ~clk;

  mod_mul_pipe_if #(.TAG_W(8)) bus ();

  mod_mul_pipe #(.TAG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MODMUL_RANGE_CHECK_EN
    .range_err (range_err),
`endif
    .bus       (bus)
  );

  task automatic chk(input string nm,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", nm, obs, exp);
    end
  endtask

  // One clock: drive after posedge, observe handshakes at negedge.
  task automatic cyc(input bit iv,
                     input logic [11:0] a,
                     input logic [11:0] b,
                     input logic [7:0] tg,
                     input bit ordy,
                     output bit accepted);
    logic [19:0] e;
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready),
        32'(!bus.out_valid || ordy));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(bus.out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("stream", {12'd0, bus.out_tag, bus.out_res},
            {12'd0, e});
      end
    end
    accepted = iv && bus.in_ready;
    if (accepted)
      exp_q.push_back({tg, 12'((32'(a) * 32'(b)) % 3329)});
  endtask

  task automatic idle(input bit ordy);
    bit dummy;
    cyc(1'b0, 12'd0, 12'd0, 8'd0, ordy, dummy);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #22;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_res", 32'(bus.out_res), 0);
    chk("rst_out_tag", 32'(bus.out_tag), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
`ifdef MODMUL_RANGE_CHECK_EN
    chk("rst_range_err", 32'(range_err), 0);
`endif

    // Latency: 3328*3328 mod q = 1.
    cyc(1'b1, 12'd3328, 12'd3328, 8'h5A, 1'b1, acc);
    chk("lat_acc", 32'(acc), 1);
    idle(1'b1);
    chk("lat_c1", 32'(bus.out_valid), 0);
    idle(1'b1);
    chk("lat_c2", 32'(bus.out_valid), 0);
    idle(1'b1);
    chk("lat_c3", 32'(bus.out_valid), 1);
    chk("lat_res", 32'(bus.out_res), 1);
    chk("lat_tag", 32'(bus.out_tag), 32'h5A);
    idle(1'b1);
    chk("lat_after", 32'(bus.out_valid), 0);

    // Back-to-back.
    cyc(1'b1, 12'd1234, 12'd2345, 8'h11, 1'b1, acc);
    cyc(1'b1, 12'd4095, 12'd4095, 8'h22, 1'b1, acc);
    cyc(1'b1, 12'd0, 12'd17, 8'h33, 1'b1, acc);
    idle(1'b1);
    chk("b2b_v0", 32'(bus.out_valid), 1);
    chk("b2b_r0", 32'(bus.out_res), 829);
    chk("b2b_t0", 32'(bus.out_tag), 32'h11);
    idle(1'b1);
    chk("b2b_v1", 32'(bus.out_valid), 1);
    chk("b2b_r1", 32'(bus.out_res), 852);
    chk("b2b_t1", 32'(bus.out_tag), 32'h22);
    idle(1'b1);
    chk("b2b_v2", 32'(bus.out_valid), 1);
    chk("b2b_r2", 32'(bus.out_res), 0);
    chk("b2b_t2", 32'(bus.out_tag), 32'h33);
    idle(1'b1);
    chk("b2b_end", 32'(bus.out_valid), 0);

    // Stall: fill with out_ready low, hold, then release.
    cyc(1'b1, 12'd100, 12'd200, 8'h40, 1'b0, acc);
    cyc(1'b1, 12'd3000, 12'd3000, 8'h41, 1'b0, acc);
    cyc(1'b1, 12'd1, 12'd3328, 8'h42, 1'b0, acc);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 12'd9, 12'd9, 8'h43, 1'b0, acc);
      chk("stall_acc", 32'(acc), 0);
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_res", 32'(bus.out_res), 26);
      chk("stall_tag", 32'(bus.out_tag), 32'h40);
    end
    idle(1'b1);
    chk("rel_r0", 32'(bus.out_res), 26);
    idle(1'b1);
    chk("rel_r1", 32'(bus.out_res), 1713);
    chk("rel_t1", 32'(bus.out_tag), 32'h41);
    idle(1'b1);
    chk("rel_r2", 32'(bus.out_res), 3328);
    idle(1'b1);
    chk("rel_end", 32'(bus.out_valid), 0);
    chk("rel_drain", 32'(exp_q.size()), 0);

    // Out-of-range operand: 3329*7 mod q = 0.
    cyc(1'b1, 12'd3329, 12'd7, 8'h77, 1'b1, acc);
    idle(1'b1);
`ifdef MODMUL_RANGE_CHECK_EN
    chk("range_set", 32'(range_err), 1);
`endif
    idle(1'b1);
    idle(1'b1);
    chk("range_v", 32'(bus.out_valid), 1);
    chk("range_res", 32'(bus.out_res), 0);
    idle(1'b1);
`ifdef MODMUL_RANGE_CHECK_EN
    chk("range_sticky", 32'(range_err), 1);
`endif

    // Random stream against the scoreboard.
    sent = 0;
    cycles = 0;
    while ((sent < 10000 || exp_q.size() > 0)
           && cycles < 60000) begin
      if (sent < 10000) begin
        cyc(1'($urandom_range(0, 3) != 0),
            12'($urandom_range(0, 4095)),
            12'($urandom_range(0, 4095)),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), acc);
        if (acc) sent++;
      end else begin
        idle(1'b1);
      end
      cycles++;
    end
    chk("rand_sent", 32'(sent), 10000);
    chk("rand_drain", 32'(exp_q.size()), 0);
    idle(1'b1);

    // Reset with three entries in flight.
    cyc(1'b1, 12'd5, 12'd6, 8'h81, 1'b1, acc);
    cyc(1'b1, 12'd7, 12'd8, 8'h82, 1'b1, acc);
    cyc(1'b1, 12'd9, 12'd10, 8'h83, 1'b1, acc);
    idle(1'b0);
    chk("flush_pre", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_res", 32'(bus.out_res), 0);
`ifdef MODMUL_RANGE_CHECK_EN
    chk("flush_rerr", 32'(range_err), 0);
`endif
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("flush_stale", 32'(bus.out_valid), 0);
    end
    cyc(1'b1, 12'd2000, 12'd3000, 8'h99, 1'b1, acc);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("post_v", 32'(bus.out_valid), 1);
    chk("post_res", 32'(bus.out_res), 1142);
    chk("post_tag", 32'(bus.out_tag), 32'h99);
    idle(1'b1);
    chk("post_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
